bram_stream_reader: RTL

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - streams a contiguous BRAM region into a valid/ready output through a 2-entry FIFO
module bram_stream_reader #(
    parameter int DWIDTH   = 64,
    parameter int MEM_SIZE = 2048,
    localparam int AWIDTH  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [AWIDTH:0]   num_i,
    output logic              idle_o,
    output logic              run_o,
    output logic              done_o,
    output logic              ce_o,
    output logic              we_o,
    output logic [AWIDTH-1:0] addr_o,
    input  logic [DWIDTH-1:0] q_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_last_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

    state_t            state_q;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   num_q;
    logic [AWIDTH:0]   issued_q, issued_d;
    logic              inflight_q;
    logic              inflight_last_q;

    logic [DWIDTH-1:0] fifo_data_q [0:1];
    logic              fifo_last_q [0:1];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              hs;
    logic              words_remain;
    logic              issue_last;
    logic [2:0]        pending;
    logic              issue;

    // Issue decision: a read may only start if its word is guaranteed a FIFO slot on capture.
    always_comb begin
        hs           = m_valid_o & m_ready_i;
        words_remain = (issued_q != num_q);
        issue_last   = (issued_q == (num_q - (AWIDTH+1)'(1)));
        pending      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, hs};
        issue        = (state_q == S_RUN) && words_remain && (pending < 3'd2);
        addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + AWIDTH'(1);
        issued_d     = issued_q + (AWIDTH+1)'(1);
        fifo_cnt_d   = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, hs};
    end

    // Control FSM plus read-issue counters; a zero-length start skips straight to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            num_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue & issue_last;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (num_i != '0) begin
                            addr_q   <= base_addr_i;
                            num_q    <= num_i;
                            issued_q <= '0;
                            state_q  <= S_RUN;
                        end else begin
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr_q   <= addr_d;
                        issued_q <= issued_d;
                    end
                    if (hs && m_last_o) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output FIFO: capture q_i exactly one cycle after each issued read, pop on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= '0;
        end else begin
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= q_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (hs) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Output decode; head-of-FIFO fields are masked to zero when nothing is valid.
    always_comb begin
        idle_o    = (state_q == S_IDLE);
        run_o     = (state_q == S_RUN);
        done_o    = (state_q == S_DONE);
        ce_o      = issue;
        we_o      = 1'b0;
        addr_o    = issue ? addr_q : '0;
        m_valid_o = (fifo_cnt_q != 2'd0);
        m_data_o  = m_valid_o ? fifo_data_q[rd_ptr_q] : '0;
        m_last_o  = m_valid_o & fifo_last_q[rd_ptr_q];
    end

endmodule
